// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_controller_pkg: state, opcode, cmd, select and condition encodings
// Rev 1.0
// ============================================================================
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv is {N,Z,C,V}; the 1111 code never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_check = z;
            COND_NE: cond_check = ~z;
            COND_CS: cond_check = c;
            COND_CC: cond_check = ~c;
            COND_MI: cond_check = n;
            COND_PL: cond_check = ~n;
            COND_VS: cond_check = v;
            COND_VC: cond_check = ~v;
            COND_HI: cond_check = c & ~z;
            COND_LS: cond_check = ~c | z;
            COND_GE: cond_check = (n == v);
            COND_LT: cond_check = (n != v);
            COND_GT: cond_check = ~z & (n == v);
            COND_LE: cond_check = z | (n != v);
            COND_AL: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_cond_unit.sv
`default_nettype none
// ============================================================================
// mc_cond_unit: NZCV flag register with split NZ/CV enables and CondEx evaluation
// Rev 1.0
// ============================================================================
module mc_cond_unit
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q;

    // CondEx always looks at the stored flags, never the ones being written.
    assign cond_ex_o = cond_check(cond_i, flags_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAG_RST;
        end else begin
            if (flag_w_i[1] && cond_ex_o) flags_q[3:2] <= alu_flags_i[3:2];
            if (flag_w_i[0] && cond_ex_o) flags_q[1:0] <= alu_flags_i[1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller: FSM sequencer and decode for the multicycle ARM-subset datapath
// Rev 1.0
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic       next_pc, branch, reg_w, mem_w, ir_w, is_exec;
    logic [1:0] cmd_alu, flag_w;
    logic       no_write, cond_ex, rd_pc;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // cmd decode; unknown commands act as a non-writing, non-flagging ADD.
    always_comb begin
        cmd_alu  = ALU_ADD;
        no_write = 1'b0;
        flag_w   = 2'b00;
        case (Funct[4:1])
            CMD_ADD: flag_w = {Funct[0], Funct[0]};
            CMD_SUB: begin cmd_alu = ALU_SUB; flag_w = {Funct[0], Funct[0]}; end
            CMD_AND: begin cmd_alu = ALU_AND; flag_w = {Funct[0], 1'b0}; end
            CMD_ORR: begin cmd_alu = ALU_ORR; flag_w = {Funct[0], 1'b0}; end
            CMD_CMP: begin cmd_alu = ALU_SUB; flag_w = {Funct[0], Funct[0]}; no_write = 1'b1; end
            default: no_write = 1'b1;
        endcase
        // Memory instructions reuse these bits as P/U/B/W, so NoWrite only means something for data-processing.
        if (Op != OP_DP) no_write = 1'b0;
    end

    always_comb begin
        state_d    = S_FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        is_exec    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: begin
                ALUControl = cmd_alu;
                is_exec    = 1'b1;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = cmd_alu;
                is_exec    = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_cond_unit #(
        .FLAG_RST (FLAG_RST)
    ) u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (is_exec ? flag_w : 2'b00),
        .cond_ex_o   (cond_ex)
    );

    assign rd_pc     = (Rd == 4'd15);
    assign IRWrite   = ~reset & ir_w;
    assign MemWrite  = ~reset & mem_w & cond_ex;
    assign RegWrite  = ~reset & reg_w & cond_ex & ~no_write & ~rd_pc;
    assign PCWrite   = ~reset & (next_pc | (cond_ex & (branch | (reg_w & ~no_write & rd_pc))));
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == OP_MEM, Op == OP_BR};
    assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller: table-driven instruction walks with a per-cycle scoreboard
// Rev 1.0
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] state_dbg;

    multicycle_controller #(.FLAG_RST(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // st/wr hold up to five per-cycle nibbles, first cycle in the top nibble.
    // wr nibble = {PCWrite, MemWrite, IRWrite, RegWrite}.
    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  aluf;
        int          len;
        logic [19:0] st;
        logic [19:0] wr;
        logic [3:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] wr;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluf,
                           input int len, input logic [19:0] st, input logic [19:0] wr,
                           input logic [3:0] flags);
        vecs[i].cond = cond;  vecs[i].op = op;    vecs[i].funct = funct;
        vecs[i].rd = rd;      vecs[i].aluf = aluf; vecs[i].len = len;
        vecs[i].st = st;      vecs[i].wr = wr;    vecs[i].flags = flags;
    endtask

    task automatic drive(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] aluf);
        Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = aluf;
    endtask

    // Entered and left at a falling edge while the DUT sits in FETCH.
    task automatic run_vec(input int i);
        exp_t e;
        drive(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].aluf);
        for (int k = 0; k < vecs[i].len; k++)
            sb.push_back({vecs[i].st[19-4*k -: 4], vecs[i].wr[19-4*k -: 4]});
        for (int k = 0; k < vecs[i].len; k++) begin
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d c%0d state", i, k), 32'(state_dbg), 32'(e.st));
            check($sformatf("v%0d c%0d writes", i, k),
                  32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'(e.wr));
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d flags", i), 32'(dut.u_cond.flags_q), 32'(vecs[i].flags));
    endtask

    // Data-processing walk checking the execute-cycle ALU selects.
    task automatic exec_sel(input string name, input logic [5:0] funct,
                            input logic [1:0] exp_ctl, input logic [1:0] exp_srcb);
        drive(4'b1110, 2'b00, funct, 4'd1, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        #1;
        check({name, " ALUControl"}, 32'(ALUControl), 32'(exp_ctl));
        check({name, " ALUSrcB"}, 32'(ALUSrcB), 32'(exp_srcb));
        @(negedge clk);
        #1;
        check({name, " ALUWB ALUControl"}, 32'(ALUControl), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set_vec( 0, 4'b0000, 2'b00, 6'b000101, 4'd2, 4'b1111, 4, 20'h01680, 20'hA0000, 4'b0000); // SUBSEQ, Z=0
        set_vec( 1, 4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0100, 4, 20'h01680, 20'hA0010, 4'b0100); // ADDS AL
        set_vec( 2, 4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000, 5, 20'h01234, 20'hA0001, 4'b0100); // LDR
        set_vec( 3, 4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000, 4, 20'h01250, 20'hA0040, 4'b0100); // STR
        set_vec( 4, 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0110, 4, 20'h01680, 20'hA0000, 4'b0110); // CMP -> Z=1
        set_vec( 5, 4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000, 3, 20'h01900, 20'hA0000, 4'b0110); // BNE not taken
        set_vec( 6, 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0000, 4, 20'h01680, 20'hA0000, 4'b0000); // CMP -> Z=0
        set_vec( 7, 4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000, 3, 20'h01900, 20'hA0800, 4'b0000); // BNE taken
        set_vec( 8, 4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000, 4, 20'h01680, 20'hA0080, 4'b0000); // ADD PC
        set_vec( 9, 4'b1110, 2'b11, 6'b000000, 4'd1, 4'b1111, 2, 20'h01000, 20'hA0000, 4'b0000); // Op=11
        set_vec(10, 4'b1110, 2'b00, 6'b111001, 4'd4, 4'b1011, 4, 20'h01780, 20'hA0010, 4'b1000); // ORRS imm: CV kept
        set_vec(11, 4'b1111, 2'b00, 6'b001000, 4'd1, 4'b0000, 4, 20'h01680, 20'hA0000, 4'b1000); // cond 1111
        set_vec(12, 4'b0100, 2'b00, 6'b001000, 4'd5, 4'b0000, 4, 20'h01680, 20'hA0010, 4'b1000); // ADDMI, N=1
        set_vec(13, 4'b1110, 2'b00, 6'b000011, 4'd6, 4'b0101, 4, 20'h01680, 20'hA0000, 4'b1000); // unknown cmd, S=1

        drive(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset state", 32'(state_dbg), 32'd0);
        check("reset writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
        check("reset flags", 32'(dut.u_cond.flags_q), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // LDR select walk, flags stay 1000
        drive(4'b1110, 2'b01, 6'b011001, 4'd3, 4'b0000);
        #1;
        check("ldr fetch srcs", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'({1'b1, 2'b10, 2'b10}));
        check("ldr RegSrc", 32'(RegSrc), 32'(2'b10));
        check("ldr ImmSrc", 32'(ImmSrc), 32'(2'b01));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("ldr memadr srcb/alu", 32'({ALUSrcB, ALUControl}), 32'({2'b01, 2'b00}));
        @(negedge clk);
        #1;
        check("ldr memread AdrSrc", 32'(AdrSrc), 32'd1);
        @(negedge clk);
        #1;
        check("ldr memwb ResultSrc", 32'(ResultSrc), 32'(2'b01));
        check("ldr memwb RegWrite", 32'(RegWrite), 32'd1);
        @(negedge clk);

        exec_sel("sub reg", 6'b000100, 2'b01, 2'b00);
        exec_sel("and reg", 6'b000000, 2'b10, 2'b00);
        exec_sel("orr imm", 6'b111000, 2'b11, 2'b01);
        exec_sel("cmp reg", 6'b010100, 2'b01, 2'b00);

        // Reset arriving in MEMWRITE with flags nonzero
        drive(4'b1110, 2'b01, 6'b011000, 4'd2, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("memwrite state", 32'(state_dbg), 32'd5);
        check("memwrite MemWrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("reset mid-memwrite MemWrite", 32'(MemWrite), 32'd0);
        @(negedge clk);
        #1;
        check("reset cyc1 state", 32'(state_dbg), 32'd0);
        check("reset cyc1 writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
        @(negedge clk);
        #1;
        check("reset cyc2 state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset writes", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'hA);
        check("post-reset flags", 32'(dut.u_cond.flags_q), 32'd0);
        @(negedge clk);
        #1;
        check("post-reset decode", 32'(state_dbg), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle sequencer for the ARM-subset datapath. It replaces per-instruction single-cycle control with an FSM that shares one ALU and one unified memory across FETCH, DECODE, EXECUTE, MEM and WB cycles. It owns the NZCV flag register and condition evaluation, and gates every architectural write enable with CondEx. It sits beside the multicycle datapath: it consumes IR fields and ALUFlags, and drives mux selects and enables.

Parameters:
FLAG_RST, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20] (I, cmd[3:0], S/L)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  N,Z,C,V from ALU, valid in the same cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=ALUOut to memory address
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  = Op
RegSrc  out  2  [0]=Op==10, [1]=Op==01
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
state_dbg  out  4  current state encoding

Behaviour:
- State register and flags register use synchronous active-high reset: state <= FETCH, flags <= FLAG_RST.
- While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- If reset is asserted mid-instruction, the next cycle is FETCH with no partial writes.
- Outputs are Moore decodes of state, plus CondEx gating.
- Default outputs: everything 0; ALUControl is 00 except in EXECUTER/EXECUTEI.

State transitions:
- FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1 -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 to ALUOut). Next state by Op/Funct:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5]=0 -> EXECUTER
  - Op=00 & Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH, no side effects
- MEMADR: ALUSrcB=01, ADD. Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemW=1 -> FETCH.
- EXECUTER: ALUSrcB=00, ALUControl from cmd -> ALUWB.
- EXECUTEI: ALUSrcB=01, ALUControl from cmd -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.

cmd decode (Funct[4:1]):
- 0100 ADD -> ALUControl 00
- 0010 SUB -> 01
- 0000 AND -> 10
- 1100 ORR -> 11
- 1010 CMP -> 01, with NoWrite=1
- Any other cmd -> 00 with NoWrite=1 and no flag update.
- FlagW[1] = S. FlagW[0] = S & (ADD|SUB|CMP).

CondEx:
- Combinational from the stored flags (pre-update) and Cond.
- Standard ARM codes 0000 EQ through 1110 AL; 1111 gives CondEx=0.

Flag update:
- NZ <= ALUFlags[3:2] at the end of an EXECUTE cycle when FlagW[1] & CondEx.
- CV <= ALUFlags[1:0] likewise, using FlagW[0].

Write gating:
- RegWrite = RegW & CondEx & ~NoWrite & (Rd != 15).
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (CondEx & (Branch | (RegW & ~NoWrite & Rd==15))).
- A false condition still walks the full state sequence, with no architectural writes.

Latency in cycles: branch 3, data-processing 4, STR 4, LDR 5.

Decomposition:
- Shared package: state encodings (FETCH=0 … BRANCH=9); Op codes; cmd codes; ALUControl codes; ResultSrc/ALUSrcB select constants; condition-code constants.
- One sub-module, mc_cond_unit: owns the NZCV register with synchronous reset, the enable split for FlagW, and CondEx evaluation. The main module keeps the FSM and decode.

Test Plan:
- Reset held 2 cycles mid-MEMWRITE -> state_dbg=0 and MemWrite=0 during reset; the next cycle shows FETCH with IRWrite=1 and flags=0000.
- ADDS, Cond=1110, ALUFlags=0100 -> sequence FETCH,DECODE,EXECUTER,ALUWB. RegWrite=1 only in ALUWB. Z=1 stored after EXECUTER. 4 cycles total.
- SUBEQ with stored Z=0 -> same 4-state walk; RegWrite, PCWrite and the flag enables all 0 after FETCH.
- LDR (Op=01, Funct[0]=1, Rd=3) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB. AdrSrc=1 in MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB.
- CMP then BNE: CMP result Z=1 -> BNE walks BRANCH with PCWrite=0. Repeat with Z=0 -> PCWrite=1 in BRANCH.
- ADD with Rd=15, AL -> RegWrite=0 and PCWrite=1 in ALUWB. Op=11 -> DECODE returns to FETCH with no writes.
